seq_pattern_gen: RTL
====================

SEQ_PATTERN_GEN -- requirements
Module: seq_pattern_gen

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the maximum pattern length in bits.
REQ-002 SHALL have parameter IDLE_LEVEL, default 1'b1, giving the W level driven when not transmitting.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes occur on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port start, input, 1, transmit request, sampled only in IDLE.
REQ-006 SHALL have port pattern, input, WIDTH, the bit pattern to send, sent MSB-first from bit length-1.
REQ-007 SHALL have port length, input, clog2(WIDTH+1), the number of pattern bits to send (0..WIDTH).
REQ-008 SHALL have port repeat_cnt, input, 4, the number of additional back-to-back repetitions (0 = send once).
REQ-009 SHALL have port W, output, 1, serial FSM-input stream for the downstream sequence detector.
REQ-010 SHALL have port _W, output, 1, complement of W.
REQ-011 SHALL have port busy, output, 1, high while bits are being driven.
REQ-012 SHALL have port done, output, 1, one-cycle completion pulse.

Function
REQ-013 SHALL implement the Moore FSM states IDLE, SHIFT and DONE, with all outputs decoded from registered state only.
REQ-014 In IDLE with start=1 at edge k, SHALL latch pattern, length and repeat_cnt, and SHALL enter SHIFT unless length=0.
REQ-015 From edge k+1, SHALL drive W = latched pattern[length-1], then one lower bit per cycle down to bit 0.
REQ-016 After bit 0, if remaining repeats > 0, SHALL decrement the repeat count and restart at bit length-1 on the very next cycle (no gap).
REQ-017 After the last bit of the last repetition, SHALL enter DONE for exactly one cycle (done=1, busy=0, W=IDLE_LEVEL), then return to IDLE.
REQ-018 Total SHIFT cycles SHALL equal length*(repeat_cnt+1); done SHALL assert on the cycle immediately after the last bit.
REQ-019 A start with length=0 SHALL go straight to DONE at edge k+1 without driving any bits.
REQ-020 A length greater than WIDTH SHALL be clamped to WIDTH.
REQ-021 Start asserted in SHIFT or DONE SHALL be ignored; input changes after latching SHALL NOT affect the transfer in progress.
REQ-022 busy SHALL be 1 exactly in SHIFT; in IDLE, W SHALL equal IDLE_LEVEL.
REQ-023 _W SHALL equal ~W in every cycle, including during reset.

Reset
REQ-024 reset=1 at a rising edge SHALL force IDLE, W=IDLE_LEVEL, _W=~IDLE_LEVEL, busy=0, done=0, and clear all counters.
REQ-025 Reset SHALL take priority over start and over an in-progress transfer; a partial pattern SHALL be abandoned with no done pulse.

Structure
REQ-026 The state encoding constants (IDLE, SHIFT, DONE) and the default WIDTH SHALL live in a shared package used by the generator and the detector test benches.
REQ-027 The bit selection and length counter SHALL be a sub-module pattern_shreg with load/shift controls and a last_bit flag; the top module holds the FSM and the repeat counter.

Verification
REQ-028 Reset: reset=1 for 2 cycles -> W=1, _W=0, busy=0, done=0.
REQ-029 Single shot: pattern=8'b0000_0110, length=3, repeat_cnt=0, start pulse -> W=1,1,0 over 3 cycles, busy high for 3 cycles, then done=1 for 1 cycle.
REQ-030 Repeat: pattern=8'b0000_0010, length=2, repeat_cnt=2 -> W=1,0,1,0,1,0 with no gap, then a single done pulse.
REQ-031 Zero/clamp: length=0 -> done at edge k+1 and busy never high; length=15 with WIDTH=8 -> exactly 8 bits sent.
REQ-032 Abort and ignore: reset at the 2nd bit of a length=5 transfer -> W=IDLE_LEVEL next cycle and no done; start pulsed during SHIFT -> no effect on the bit stream.
REQ-033 Loopback: W/_W are fed to the existing detector and a pattern containing the target sequence is sent -> Zout asserts on the expected cycle, and every cycle is checked for _W==~W.

Source files
------------

// File: rtl/seq_pattern_gen_pkg.sv
// Shared definitions for the serial pattern generator and the sequence-detector
// benches: FSM state encoding, default pattern width and a length clamp helper.
package seq_pattern_gen_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } gen_state_e;

  // Limit a requested pattern length to the physical pattern width.
  function automatic int clamp_len(input int len, input int max_len);
    if (len > max_len) begin
      return max_len;
    end else begin
      return len;
    end
  endfunction

endpackage

// File: rtl/seq_pattern_gen_shreg.sv
// Bit selector for the pattern generator. The latched pattern is left-aligned
// so that the bit being driven is always the MSB of the working register; a
// down-counter tracks how many bits of the current repetition remain.
module pattern_shreg
  import seq_pattern_gen_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int LW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             reload,
  input  logic             shift,
  input  logic [WIDTH-1:0] pattern,
  input  logic [LW-1:0]    length,
  output logic             next_bit,
  output logic             last_bit,
  output logic             len_zero
);

  logic [WIDTH-1:0] pat_r;
  logic [WIDTH-1:0] shift_r;
  logic [LW-1:0]    len_r;
  logic [LW-1:0]    cnt_r;
  logic [LW-1:0]    len_c_s;
  logic [WIDTH-1:0] aligned_s;
  logic [WIDTH-1:0] shifted_s;

  // Clamp the requested length and left-align the pattern so bit length-1 lands on the MSB.
  always_comb begin
    len_c_s   = LW'(clamp_len(int'(length), WIDTH));
    aligned_s = pattern << (LW'(WIDTH) - len_c_s);
    shifted_s = shift_r << 1;
  end

  // Select the bit that becomes visible on W after the coming clock edge.
  always_comb begin
    next_bit = 1'b0;
    if (load) begin
      next_bit = aligned_s[WIDTH-1];
    end else if (reload) begin
      next_bit = pat_r[WIDTH-1];
    end else begin
      next_bit = shifted_s[WIDTH-1];
    end
  end

  assign last_bit = (cnt_r == LW'(1));
  assign len_zero = (len_c_s == LW'(0));

  // Latch, restart or advance the working pattern and remaining-bit counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      pat_r   <= '0;
      shift_r <= '0;
      len_r   <= '0;
      cnt_r   <= '0;
    end else if (load) begin
      pat_r   <= aligned_s;
      shift_r <= aligned_s;
      len_r   <= len_c_s;
      cnt_r   <= len_c_s;
    end else if (reload) begin
      shift_r <= pat_r;
      cnt_r   <= len_r;
    end else if (shift) begin
      shift_r <= shifted_s;
      cnt_r   <= cnt_r - LW'(1);
    end else begin
      shift_r <= shift_r;
      cnt_r   <= cnt_r;
    end
  end

endmodule

// File: rtl/seq_pattern_gen.sv
// Serial pattern generator: sends the low `length` bits of `pattern` MSB-first
// on W, optionally repeated back-to-back, then pulses done for one cycle.
// W, busy and done are flops updated together with the state register.
module seq_pattern_gen
  import seq_pattern_gen_pkg::*;
#(
  parameter int   WIDTH      = DEFAULT_WIDTH,
  parameter logic IDLE_LEVEL = 1'b1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [WIDTH-1:0]           pattern,
  input  logic [$clog2(WIDTH+1)-1:0] length,
  input  logic [3:0]                 repeat_cnt,
  output logic                       W,
  output logic                       _W,
  output logic                       busy,
  output logic                       done
);

  localparam int LW = $clog2(WIDTH + 1);

  gen_state_e state_r;
  logic [3:0] rep_r;
  logic       w_r;
  logic       busy_r;
  logic       done_r;
  logic       load_s;
  logic       reload_s;
  logic       shift_s;
  logic       next_bit_s;
  logic       last_bit_s;
  logic       len_zero_s;

  pattern_shreg #(
    .WIDTH (WIDTH),
    .LW    (LW)
  ) u_shreg (
    .clk      (clk),
    .reset    (reset),
    .load     (load_s),
    .reload   (reload_s),
    .shift    (shift_s),
    .pattern  (pattern),
    .length   (length),
    .next_bit (next_bit_s),
    .last_bit (last_bit_s),
    .len_zero (len_zero_s)
  );

  // Derive shift-register controls from the current state and bit position.
  always_comb begin
    load_s   = 1'b0;
    reload_s = 1'b0;
    shift_s  = 1'b0;
    case (state_r)
      IDLE: begin
        load_s = start;
      end
      SHIFT: begin
        if (last_bit_s) begin
          reload_s = (rep_r != 4'd0);
        end else begin
          shift_s = 1'b1;
        end
      end
      DONE: begin
        load_s = 1'b0;
      end
      default: begin
        load_s = 1'b0;
      end
    endcase
  end

  // Transfer FSM with registered W/busy/done and the repetition counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      rep_r   <= 4'd0;
      w_r     <= IDLE_LEVEL;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            rep_r <= repeat_cnt;
            if (len_zero_s) begin
              state_r <= DONE;
              w_r     <= IDLE_LEVEL;
              busy_r  <= 1'b0;
              done_r  <= 1'b1;
            end else begin
              state_r <= SHIFT;
              w_r     <= next_bit_s;
              busy_r  <= 1'b1;
              done_r  <= 1'b0;
            end
          end else begin
            w_r    <= IDLE_LEVEL;
            busy_r <= 1'b0;
            done_r <= 1'b0;
          end
        end
        SHIFT: begin
          if (last_bit_s && (rep_r == 4'd0)) begin
            state_r <= DONE;
            w_r     <= IDLE_LEVEL;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
          end else begin
            if (last_bit_s) begin
              rep_r <= rep_r - 4'd1;
            end else begin
              rep_r <= rep_r;
            end
            w_r <= next_bit_s;
          end
        end
        DONE: begin
          state_r <= IDLE;
          w_r     <= IDLE_LEVEL;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
        default: begin
          state_r <= IDLE;
          rep_r   <= 4'd0;
          w_r     <= IDLE_LEVEL;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  assign W    = w_r;
  assign _W   = ~w_r;
  assign busy = busy_r;
  assign done = done_r;

endmodule
